// File: rtl/vector_cmd_queue.sv
// vector_cmd_queue
//
// Buffers packed vector commands from the host in a synchronous FIFO. It issues
// each command to the downstream `control` block only while `control` reports
// ready. Each issue is a stable x/y pair plus a one-cycle jump or draw pulse.
// EOF words produce a frame_end pulse instead. NOP words are consumed without
// any visible effect.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   wr_en      push wr_data this cycle
//   wr_data    command word: [25:24] op (00 NOP, 01 JUMP, 10 DRAW, 11 EOF),
//              [23:12] x, [11:0] y
//   flush      synchronous FIFO clear, also clears overflow
//   halt       blocks new pops; an in-flight word still completes
//   ctl_ready  ready from control
//   x, y       registered coordinates to control
//   jump       one-cycle jump pulse
//   draw       one-cycle draw pulse
//   frame_end  one-cycle pulse when an EOF word issues
//   empty      FIFO empty
//   full       FIFO full
//   count      words currently stored
//   overflow   sticky: a write was dropped because the FIFO was full

module vector_cmd_queue #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [25:0]       wr_data,
  input  logic              flush,
  input  logic              halt,
  input  logic              ctl_ready,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              jump,
  output logic              draw,
  output logic              frame_end,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned    Depth  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PtrOne = 1;

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpJump = 2'b01;
  localparam logic [1:0] OpDraw = 2'b10;
  localparam logic [1:0] OpEof  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPulse,
    StSettle
  } state_e;

  logic [25:0]     mem_q [Depth];
  logic [ADDR_W:0] wr_ptr_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic            overflow_q;

  state_e          state_q;
  logic [25:0]     rd_data_q;
  logic [11:0]     x_q;
  logic [11:0]     y_q;
  logic            jump_q;
  logic            draw_q;
  logic            frame_end_q;

  logic            do_write;
  logic            do_pop;

  // Extra pointer bit distinguishes full (wrap bits differ) from empty.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign do_write = wr_en && !full && !flush;
  assign do_pop   = (state_q == StIdle) && !empty && ctl_ready && !halt && !flush;

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      // Flush wins over any write this cycle and never raises overflow.
      rd_ptr_q   <= wr_ptr_q;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      // A full FIFO drops the word even when a pop frees a slot this cycle.
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_data_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      jump_q      <= 1'b0;
      draw_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (do_pop) begin
            rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          case (rd_data_q[25:24])
            OpJump: begin
              x_q     <= rd_data_q[23:12];
              y_q     <= rd_data_q[11:0];
              jump_q  <= 1'b1;
              state_q <= StPulse;
            end
            OpDraw: begin
              x_q     <= rd_data_q[23:12];
              y_q     <= rd_data_q[11:0];
              draw_q  <= 1'b1;
              state_q <= StPulse;
            end
            OpEof: begin
              frame_end_q <= 1'b1;
              state_q     <= StPulse;
            end
            OpNop: begin
              state_q <= StIdle;
            end
          endcase
        end
        StPulse: begin
          jump_q      <= 1'b0;
          draw_q      <= 1'b0;
          frame_end_q <= 1'b0;
          state_q     <= StSettle;
        end
        StSettle: begin
          // control's ready lags the pulse, so skip one cycle before popping again.
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign jump      = jump_q;
  assign draw      = draw_q;
  assign frame_end = frame_end_q;
  assign overflow  = overflow_q;

endmodule
